// File: rtl/mips_pc_pkg.sv
// Shared types and widths for the fetch PC sequencer.
// Contents: sequencer state enum, PC step size, instruction field widths,
// flush counter width.
package mips_pc_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned J_IDX_W     = 26;
    localparam int unsigned IMM_W       = 16;
    localparam int unsigned FLUSH_CNT_W = 2;

    localparam logic [PC_W-1:0] PC_INCR = 32'd4;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_RUN      = 2'd1,
        S_FLUSHING = 2'd2,
        S_ERROR    = 2'd3
    } pc_state_e;

endpackage

// File: rtl/next_pc_sequencer_if.sv
// Decode/fetch-side bundle of the PC sequencer.
// slave  : the sequencer (consumes control, drives pc/pc_valid/flush/addr_err)
// master : the environment (decode + fetch) driving control and observing the PC
interface next_pc_sequencer_if;
    import mips_pc_pkg::*;

    logic                 start;
    logic                 stall;
    logic                 if_ready;
    logic [PC_W-1:0]      id_pc4;
    logic                 jump;
    logic [J_IDX_W-1:0]   j_target;
    logic                 branch;
    logic                 br_taken;
    logic [IMM_W-1:0]     br_offset;
    logic                 jr;
    logic [PC_W-1:0]      jr_addr;
    logic [PC_W-1:0]      pc;
    logic                 pc_valid;
    logic                 flush;
    logic                 addr_err;

    modport master (
        output start, stall, if_ready, id_pc4, jump, j_target,
               branch, br_taken, br_offset, jr, jr_addr,
        input  pc, pc_valid, flush, addr_err
    );

    modport slave (
        input  start, stall, if_ready, id_pc4, jump, j_target,
               branch, br_taken, br_offset, jr, jr_addr,
        output pc, pc_valid, flush, addr_err
    );

endinterface

// File: rtl/next_pc_sequencer_pc_target_calc.sv
// Combinational control-transfer target formation.
// Inputs : id_pc4 (PC+4 of decode instr), j_target (instr_index),
//          br_offset (branch immediate), jr_addr_lsb (low bits of JR register)
// Outputs: jump_target_c, branch_target_c, jr_misaligned_c
module pc_target_calc
    import mips_pc_pkg::*;
(
    input  logic [PC_W-1:0]    id_pc4,
    input  logic [J_IDX_W-1:0] j_target,
    input  logic [IMM_W-1:0]   br_offset,
    input  logic [1:0]         jr_addr_lsb,
    output logic [PC_W-1:0]    jump_target_c,
    output logic [PC_W-1:0]    branch_target_c,
    output logic               jr_misaligned_c
);

    // J/JAL keeps the 256 MB region of the delay-slot PC
    assign jump_target_c   = {id_pc4[PC_W-1:PC_W-4], j_target, 2'b00};
    // sign-extended word offset; wraps modulo 2^32
    assign branch_target_c = id_pc4 + {{14{br_offset[IMM_W-1]}}, br_offset, 2'b00};
    assign jr_misaligned_c = |jr_addr_lsb;

endmodule

// File: rtl/next_pc_sequencer.sv
// Fetch PC owner: sequential PC+4, J/JAL, taken branch and JR redirects,
// registered flush of wrong-path fetches, sticky misaligned-JR error.
// Ports: clk, rst_n (async, active-low), bus (next_pc_sequencer_if.slave).
// Parameters: RESET_VECTOR (word-aligned), FLUSH_CYCLES (1..3).
module next_pc_sequencer
    import mips_pc_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    next_pc_sequencer_if.slave bus
);

    pc_state_e               state_q;
    logic [PC_W-1:0]         pc_q;
    logic                    pc_valid_q;
    logic                    flush_q;
    logic                    addr_err_q;
    logic [FLUSH_CNT_W-1:0]  flush_cnt_q;

    logic [PC_W-1:0]         jump_target_c;
    logic [PC_W-1:0]         branch_target_c;
    logic                    jr_misaligned_c;
    logic [PC_W-1:0]         pc_seq_c;
    logic                    redirect_c;
    logic [PC_W-1:0]         target_c;

    pc_target_calc u_target (
        .id_pc4          (bus.id_pc4),
        .j_target        (bus.j_target),
        .br_offset       (bus.br_offset),
        .jr_addr_lsb     (bus.jr_addr[1:0]),
        .jump_target_c   (jump_target_c),
        .branch_target_c (branch_target_c),
        .jr_misaligned_c (jr_misaligned_c)
    );

    // Sequential rule shared by RUN and FLUSHING
    assign pc_seq_c = (bus.if_ready && !bus.stall) ? pc_q + PC_INCR : pc_q;

    // Redirect select, priority JR > JUMP > taken branch; misaligned JR handled separately
    always_comb begin
        redirect_c = 1'b0;
        target_c   = pc_q;
        if (bus.jr) begin
            redirect_c = 1'b1;
            target_c   = bus.jr_addr;
        end else if (bus.jump) begin
            redirect_c = 1'b1;
            target_c   = jump_target_c;
        end else if (bus.branch && bus.br_taken) begin
            redirect_c = 1'b1;
            target_c   = branch_target_c;
        end
    end

    // Sequencer FSM with PC register, flush counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            pc_q        <= RESET_VECTOR;
            pc_valid_q  <= 1'b0;
            flush_q     <= 1'b0;
            addr_err_q  <= 1'b0;
            flush_cnt_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    pc_q <= RESET_VECTOR;
                    if (bus.start) begin
                        state_q    <= S_RUN;
                        pc_valid_q <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (bus.jr && jr_misaligned_c) begin
                        state_q    <= S_ERROR;
                        pc_valid_q <= 1'b0;
                        addr_err_q <= 1'b1;
                        flush_q    <= 1'b0;
                    end else if (redirect_c) begin
                        state_q     <= S_FLUSHING;
                        pc_q        <= target_c;
                        flush_q     <= 1'b1;
                        // first flush cycle is the one right after the redirect
                        flush_cnt_q <= FLUSH_CNT_W'(FLUSH_CYCLES - 1);
                    end else begin
                        pc_q <= pc_seq_c;
                    end
                end
                S_FLUSHING: begin
                    pc_q <= pc_seq_c;
                    if (flush_cnt_q == '0) begin
                        state_q <= S_RUN;
                        flush_q <= 1'b0;
                    end else begin
                        flush_cnt_q <= flush_cnt_q - FLUSH_CNT_W'(1);
                    end
                end
                S_ERROR: begin
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.pc       = pc_q;
    assign bus.pc_valid = pc_valid_q;
    assign bus.flush    = flush_q;
    assign bus.addr_err = addr_err_q;

endmodule

// File: doc/next_pc_sequencer.md
# next_pc_sequencer

Program-counter sequencer for the 32-bit MIPS core. It owns the fetch PC and sequences it across four sources: sequential PC+4, J/JAL target formation ({PC+4[31:28], target26, 2'b00}), taken-branch offset addition and JR register targets. It sits between decode (which resolves control transfers) and instruction fetch, and issues a registered flush to kill wrong-path fetches.

## Interface
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset; must be word-aligned
- FLUSH_CYCLES, 1, cycles FLUSH stays high after a redirect; legal range 1..3
- CLK  in  1  single clock, rising edge
- RST_N  in  1  reset, asynchronous, active-low
- START  in  1  leave IDLE and begin fetching
- STALL  in  1  hold PC (pipeline hazard)
- IF_READY  in  1  fetch accepts the presented PC this cycle
- ID_PC4  in  32  PC+4 of the instruction in decode
- JUMP  in  1  decode holds J/JAL
- J_TARGET  in  26  instr_index field
- BRANCH  in  1  decode holds a conditional branch
- BR_TAKEN  in  1  branch condition true; qualified by BRANCH
- BR_OFFSET  in  16  branch immediate
- JR  in  1  decode holds JR/JALR
- JR_ADDR  in  32  register target
- PC  out  32  fetch address
- PC_VALID  out  1  PC is a valid fetch request
- FLUSH  out  1  kill instruction in IF/ID
- ADDR_ERR  out  1  sticky misaligned-JR error

## Operation
- States: IDLE, RUN, FLUSHING, ERROR.
- IDLE: PC=RESET_VECTOR, PC_VALID=0; START -> RUN. Control inputs ignored.
- RUN: PC_VALID=1. Redirect priority JR > JUMP > (BRANCH & BR_TAKEN); BRANCH with BR_TAKEN=0 is not a redirect.
- Jump target = {ID_PC4[31:28], J_TARGET, 2'b00}.
- Branch target = ID_PC4 + {{14{BR_OFFSET[15]}}, BR_OFFSET, 2'b00}, modulo 2^32.
- JR target = JR_ADDR; if JR_ADDR[1:0] != 0 -> ERROR instead of redirect.
- Redirect: PC <= target, -> FLUSHING, flush counter loaded. Redirect overrides STALL and IF_READY.
- No redirect: PC <= PC+4 when IF_READY & !STALL, else hold. 32'hFFFF_FFFC + 4 wraps to 0.
- FLUSHING: FLUSH=1, PC_VALID=1, all redirect inputs ignored (wrong-path). PC advances by the RUN sequential rule. -> RUN after FLUSH_CYCLES cycles.
- ERROR: PC_VALID=0, ADDR_ERR=1, PC frozen at its last value, FLUSH=0. Exit only by reset.
- START outside IDLE has no effect.

## Timing
- Reset (asynchronous, any state, mid-flush included): PC=RESET_VECTOR, PC_VALID=0, FLUSH=0, ADDR_ERR=0, state IDLE, counter 0.
- All outputs are registered; no combinational input-to-output paths.
- START in cycle n: PC_VALID=1 in cycle n+1.
- Redirect sampled in cycle n: new PC and FLUSH=1 in cycle n+1; FLUSH high exactly in cycles n+1..n+FLUSH_CYCLES; redirects accepted again from cycle n+FLUSH_CYCLES+1.
- Misaligned JR in cycle n: ADDR_ERR=1 and PC_VALID=0 from cycle n+1.
- Sequential advance: one PC step per accepted cycle, zero bubbles.

## Structure
- Package mips_pc_pkg: state enum, PC_INCR=32'd4, field widths (26-bit index, 16-bit immediate), flush counter width (2 bits).
- One sub-module, pc_target_calc (combinational): produces jump target, branch target and JR alignment flag. The FSM, counter and PC register live in next_pc_sequencer.

## Test plan
- Reset/start: RESET_VECTOR=32'h0040_0000, START, IF_READY=1 for 3 cycles -> PC 0040_0000, 0040_0004, 0040_0008, 0040_000C; PC_VALID rises one cycle after START.
- Jump: ID_PC4=32'h9000_0010, J_TARGET=26'h000_0100, JUMP=1 -> next cycle PC=32'h9000_0400, FLUSH=1 for FLUSH_CYCLES cycles; JUMP asserted during flush is ignored.
- Branch backward/forward: ID_PC4=32'h0000_1000, BR_OFFSET=16'hFFFF, taken -> PC=32'h0000_0FFC; BR_TAKEN=0 -> PC+4, FLUSH=0; ID_PC4=32'hFFFF_FFF0, offset 16'h0008 -> PC=32'h0000_0010 (wrap).
- Priority/stall: JR=1 (JR_ADDR=32'h0000_2000), JUMP=1 and STALL=1 together -> PC=32'h0000_2000; STALL alone for 4 cycles -> PC constant; PC=32'hFFFF_FFFC advances to 0.
- Error: JR_ADDR=32'h0000_2002 -> ADDR_ERR=1, PC_VALID=0, PC frozen, stays through START; RST_N low asynchronously -> all outputs at reset values before the next CLK edge.
